// File: rtl/pal_timing_generator.sv
// Free-running PAL raster/subcarrier timing source: 312-line progressive frames,
// subcarrier phase, sync/burst/blank windows and pixel coordinates.
module pal_timing_generator #(
  parameter int unsigned LINE_CLOCKS       = 4540,
  parameter int unsigned HSYNC_CLOCKS      = 333,
  parameter int unsigned BURST_START       = 397,
  parameter int unsigned BURST_CLOCKS      = 160,
  parameter int unsigned ACTIVE_START      = 745,
  parameter int unsigned ACTIVE_CLOCKS     = 3680,
  parameter int unsigned FRAME_LINES       = 312,
  parameter int unsigned VSYNC_LINES       = 3,
  parameter int unsigned ACTIVE_LINE_START = 40,
  parameter int unsigned ACTIVE_LINES      = 240
) (
  input  logic        phaseClock,
  input  logic        reset,
  output logic [3:0]  subcarrierPhase,
  output logic        sync,
  output logic        burst,
  output logic        blank,
  output logic        linePhase,
  output logic        active,
  output logic [12:0] hCount,
  output logic [8:0]  vCount,
  output logic        lineStart,
  output logic        frameStart
);

  localparam int unsigned H_W     = 13;
  localparam int unsigned V_W     = 9;
  localparam int unsigned PHASE_W = 4;

  if (!(HSYNC_CLOCKS < BURST_START) ||
      !(BURST_START + BURST_CLOCKS <= ACTIVE_START) ||
      !(ACTIVE_START + ACTIVE_CLOCKS <= LINE_CLOCKS) ||
      !(VSYNC_LINES <= ACTIVE_LINE_START) ||
      !(ACTIVE_LINE_START + ACTIVE_LINES <= FRAME_LINES) ||
      !(LINE_CLOCKS <= 8192) || !(FRAME_LINES <= 512)) begin : g_param_error
    $error("pal_timing_generator: illegal timing parameters");
  end

  logic [H_W-1:0]     hNext;
  logic [V_W-1:0]     vNext;
  logic [PHASE_W-1:0] phaseNext;
  logic               linePhaseNext;
  logic [31:0]        hWide;
  logic [31:0]        vWide;
  logic               vsyncLine;
  logic               syncNext;
  logic               burstNext;
  logic               activeNext;
  logic               lineStartNext;
  logic               frameStartNext;

  // Next-state counters; flags are decoded from these so they line up with the coordinates.
  always_comb begin
    hNext         = hCount + H_W'(1);
    vNext         = vCount;
    phaseNext     = subcarrierPhase + PHASE_W'(1);
    linePhaseNext = linePhase;

    if (32'(hCount) == LINE_CLOCKS - 32'd1) begin
      hNext         = '0;
      linePhaseNext = ~linePhase;
      if (32'(vCount) == FRAME_LINES - 32'd1) begin
        vNext = '0;
      end else begin
        vNext = vCount + V_W'(1);
      end
    end

    hWide     = 32'(hNext);
    vWide     = 32'(vNext);
    vsyncLine = vWide < VSYNC_LINES;

    // Broad pulses on vsync lines: sync held for all but the last HSYNC_CLOCKS of the line.
    if (vsyncLine) begin
      syncNext = hWide < (LINE_CLOCKS - HSYNC_CLOCKS);
    end else begin
      syncNext = hWide < HSYNC_CLOCKS;
    end

    burstNext = !vsyncLine && (hWide >= BURST_START) &&
                (hWide < BURST_START + BURST_CLOCKS);

    activeNext = (hWide >= ACTIVE_START) && (hWide < ACTIVE_START + ACTIVE_CLOCKS) &&
                 (vWide >= ACTIVE_LINE_START) &&
                 (vWide < ACTIVE_LINE_START + ACTIVE_LINES);

    lineStartNext  = (hNext == '0);
    frameStartNext = lineStartNext && (vNext == '0);
  end

  always_ff @(posedge phaseClock) begin
    if (reset) begin
      hCount          <= '0;
      vCount          <= '0;
      subcarrierPhase <= '0;
      linePhase       <= 1'b0;
      sync            <= 1'b1;
      burst           <= 1'b0;
      blank           <= 1'b1;
      active          <= 1'b0;
      lineStart       <= 1'b1;
      frameStart      <= 1'b1;
    end else begin
      hCount          <= hNext;
      vCount          <= vNext;
      subcarrierPhase <= phaseNext;
      linePhase       <= linePhaseNext;
      sync            <= syncNext;
      burst           <= burstNext;
      blank           <= ~activeNext;
      active          <= activeNext;
      lineStart       <= lineStartNext;
      frameStart      <= frameStartNext;
    end
  end

endmodule

// File: tb/tb_pal_timing_generator.sv
// Bench for pal_timing_generator: a full-size instance for line-level timing and a
// shrunken instance for frame-level behaviour, both checked against a cycle-count model.
module tb_pal_timing_generator;

  typedef struct packed {
    int line; int hs; int bs; int bc; int actS; int ac;
    int fl; int vs; int als; int al;
  } cfg_t;

  typedef struct packed {
    logic [3:0]  ph;
    logic        sync;
    logic        burst;
    logic        blank;
    logic        lp;
    logic        active;
    logic [12:0] h;
    logic [8:0]  v;
    logic        ls;
    logic        fs;
  } obs_t;

  localparam cfg_t CA = '{line: 4540, hs: 333, bs: 397, bc: 160, actS: 745, ac: 3680,
                          fl: 312, vs: 3, als: 40, al: 240};
  localparam cfg_t CB = '{line: 70, hs: 5, bs: 7, bc: 4, actS: 14, ac: 40,
                          fl: 21, vs: 3, als: 5, al: 10};

  localparam obs_t RST_EXP = '{ph: 4'd0, sync: 1'b1, burst: 1'b0, blank: 1'b1, lp: 1'b0,
                               active: 1'b0, h: 13'd0, v: 9'd0, ls: 1'b1, fs: 1'b1};
  localparam obs_t REL_EXP = '{ph: 4'd1, sync: 1'b1, burst: 1'b0, blank: 1'b1, lp: 1'b0,
                               active: 1'b0, h: 13'd1, v: 9'd0, ls: 1'b0, fs: 1'b0};

  logic phaseClock = 1'b0;
  always #7 phaseClock = ~phaseClock;

  logic resetA, resetB;
  logic [3:0] phA, phB;
  logic syncA, burstA, blankA, lpA, actA, lsA, fsA;
  logic syncB, burstB, blankB, lpB, actB, lsB, fsB;
  logic [12:0] hA, hB;
  logic [8:0] vA, vB;
  obs_t oA, oB;
  longint tA, tB;
  int total = 0;
  int bad = 0;

  assign oA = {phA, syncA, burstA, blankA, lpA, actA, hA, vA, lsA, fsA};
  assign oB = {phB, syncB, burstB, blankB, lpB, actB, hB, vB, lsB, fsB};

  pal_timing_generator dutA (
    .phaseClock(phaseClock), .reset(resetA), .subcarrierPhase(phA), .sync(syncA),
    .burst(burstA), .blank(blankA), .linePhase(lpA), .active(actA), .hCount(hA),
    .vCount(vA), .lineStart(lsA), .frameStart(fsA));

  pal_timing_generator #(
    .LINE_CLOCKS(70), .HSYNC_CLOCKS(5), .BURST_START(7), .BURST_CLOCKS(4),
    .ACTIVE_START(14), .ACTIVE_CLOCKS(40), .FRAME_LINES(21), .VSYNC_LINES(3),
    .ACTIVE_LINE_START(5), .ACTIVE_LINES(10)
  ) dutB (
    .phaseClock(phaseClock), .reset(resetB), .subcarrierPhase(phB), .sync(syncB),
    .burst(burstB), .blank(blankB), .linePhase(lpB), .active(actB), .hCount(hB),
    .vCount(vB), .lineStart(lsB), .frameStart(fsB));

  // Elapsed cycles since the last reset edge; all expectations derive from this.
  always @(posedge phaseClock) begin
    tA <= resetA ? longint'(0) : tA + longint'(1);
    tB <= resetB ? longint'(0) : tB + longint'(1);
  end

  function automatic obs_t model(input longint t, input cfg_t c);
    obs_t m;
    longint ln;
    int h, v;
    bit vsl;
    ln  = t / longint'(c.line);
    h   = int'(t % longint'(c.line));
    v   = int'(ln % longint'(c.fl));
    vsl = v < c.vs;
    m.ph     = 4'(t % longint'(16));
    m.lp     = ln[0];
    m.h      = 13'(h);
    m.v      = 9'(v);
    m.sync   = vsl ? (h < c.line - c.hs) : (h < c.hs);
    m.burst  = !vsl && h >= c.bs && h < c.bs + c.bc;
    m.active = h >= c.actS && h < c.actS + c.ac && v >= c.als && v < c.als + c.al;
    m.blank  = !m.active;
    m.ls     = h == 0;
    m.fs     = h == 0 && v == 0;
    return m;
  endfunction

  task automatic test_reset();
    @(negedge phaseClock);
    resetA = 1'b1; resetB = 1'b1;
    @(negedge phaseClock);
    total++; if (oA !== RST_EXP) begin bad++; $display("FAIL reset_a got=%h exp=%h", oA, RST_EXP); end
    total++; if (oB !== RST_EXP) begin bad++; $display("FAIL reset_b got=%h exp=%h", oB, RST_EXP); end
    @(negedge phaseClock);
    total++; if (oA !== RST_EXP) begin bad++; $display("FAIL reset_held got=%h exp=%h", oA, RST_EXP); end
    resetA = 1'b0; resetB = 1'b0;
    @(negedge phaseClock);
    total++; if (oA !== REL_EXP) begin bad++; $display("FAIL release_a got=%h exp=%h", oA, REL_EXP); end
    total++; if (oB !== REL_EXP) begin bad++; $display("FAIL release_b got=%h exp=%h", oB, REL_EXP); end
  endtask

  task automatic test_line_timing();
    obs_t exp, firstGot, firstExp;
    int nerr = 0;
    int vsBurst = 0;
    int actCnt = 0;
    longint hh, ln;
    while (tA < longint'(6 * 4540)) begin
      exp = model(tA, CA);
      hh = tA % 4540;
      ln = tA / 4540;
      if (oA !== exp) begin
        if (nerr == 0) begin firstGot = oA; firstExp = exp; end
        nerr++;
      end
      if (ln < 3 && burstA === 1'b1) vsBurst++;
      if (actA !== 1'b0) actCnt++;
      if (ln == 5 && hh == 332) begin total++; if (syncA !== 1'b1) begin bad++; $display("FAIL sync_h332 got=%b exp=1", syncA); end end
      if (ln == 5 && hh == 333) begin total++; if (syncA !== 1'b0) begin bad++; $display("FAIL sync_h333 got=%b exp=0", syncA); end end
      if (ln == 1 && hh == 4206) begin total++; if (syncA !== 1'b1) begin bad++; $display("FAIL broad_h4206 got=%b exp=1", syncA); end end
      if (ln == 1 && hh == 4207) begin total++; if (syncA !== 1'b0) begin bad++; $display("FAIL broad_h4207 got=%b exp=0", syncA); end end
      if (ln == 5 && hh == 396) begin total++; if (burstA !== 1'b0) begin bad++; $display("FAIL burst_h396 got=%b exp=0", burstA); end end
      if (ln == 5 && hh == 397) begin total++; if (burstA !== 1'b1) begin bad++; $display("FAIL burst_h397 got=%b exp=1", burstA); end end
      if (ln == 5 && hh == 556) begin total++; if (burstA !== 1'b1) begin bad++; $display("FAIL burst_h556 got=%b exp=1", burstA); end end
      if (ln == 5 && hh == 557) begin total++; if (burstA !== 1'b0) begin bad++; $display("FAIL burst_h557 got=%b exp=0", burstA); end end
      if (ln >= 1 && hh == 0) begin
        total++;
        if (phA !== 4'((12 * ln) % 16) || lpA !== ln[0] || lsA !== 1'b1) begin
          bad++;
          $display("FAIL line_start_%0d got ph=%0d lp=%b ls=%b exp ph=%0d lp=%b ls=1",
                   ln, phA, lpA, lsA, (12 * ln) % 16, ln[0]);
        end
      end
      @(negedge phaseClock);
    end
    total++; if (nerr != 0) begin bad++; $display("FAIL line_scan errs=%0d first got=%h exp=%h", nerr, firstGot, firstExp); end
    total++; if (vsBurst != 0) begin bad++; $display("FAIL vsync_burst got=%0d exp=0", vsBurst); end
    total++; if (actCnt != 0) begin bad++; $display("FAIL early_active got=%0d exp=0", actCnt); end
  endtask

  task automatic test_mid_line_reset();
    int guard = 0;
    while (tA % 4540 != 2000 && guard < 5000) begin @(negedge phaseClock); guard++; end
    total++; if (hA !== 13'd2000 || vA !== 9'(tA / 4540)) begin bad++; $display("FAIL pre_reset got h=%0d v=%0d exp h=2000 v=%0d", hA, vA, tA / 4540); end
    resetA = 1'b1;
    @(negedge phaseClock);
    resetA = 1'b0;
    total++; if (oA !== RST_EXP) begin bad++; $display("FAIL midline_reset got=%h exp=%h", oA, RST_EXP); end
    @(negedge phaseClock);
    total++; if (oA !== REL_EXP) begin bad++; $display("FAIL midline_release got=%h exp=%h", oA, REL_EXP); end
  endtask

  task automatic test_small_frame();
    obs_t exp, firstGot, firstExp;
    int nerr = 0;
    int actCnt = 0;
    longint hh, vv;
    for (int i = 0; i < 2 * 1470; i++) begin
      exp = model(tB, CB);
      hh = tB % 70;
      vv = (tB / 70) % 21;
      if (oB !== exp) begin
        if (nerr == 0) begin firstGot = oB; firstExp = exp; end
        nerr++;
      end
      if (actB === 1'b1) actCnt++;
      if (vv == 5 && hh == 13) begin total++; if (actB !== 1'b0) begin bad++; $display("FAIL act_h13 got=%b exp=0", actB); end end
      if (vv == 5 && hh == 14) begin total++; if (actB !== 1'b1 || blankB !== 1'b0) begin bad++; $display("FAIL act_h14 got=%b%b exp=10", actB, blankB); end end
      if (vv == 5 && hh == 53) begin total++; if (actB !== 1'b1) begin bad++; $display("FAIL act_h53 got=%b exp=1", actB); end end
      if (vv == 5 && hh == 54) begin total++; if (actB !== 1'b0 || blankB !== 1'b1) begin bad++; $display("FAIL act_h54 got=%b%b exp=01", actB, blankB); end end
      if (vv == 4 && hh == 30) begin total++; if (actB !== 1'b0) begin bad++; $display("FAIL act_line4 got=%b exp=0", actB); end end
      if (vv == 15 && hh == 30) begin total++; if (actB !== 1'b0) begin bad++; $display("FAIL act_line15 got=%b exp=0", actB); end end
      @(negedge phaseClock);
    end
    total++; if (nerr != 0) begin bad++; $display("FAIL frame_scan errs=%0d first got=%h exp=%h", nerr, firstGot, firstExp); end
    total++; if (actCnt != 800) begin bad++; $display("FAIL active_count got=%0d exp=800", actCnt); end
  endtask

  task automatic test_frame_period();
    int guard = 0;
    int cnt;
    // Random mid-frame reset point inside line 12.
    int target = 12 * 70 + int'($urandom_range(1, 69));
    while (tB % 1470 != longint'(target) && guard < 3000) begin @(negedge phaseClock); guard++; end
    resetB = 1'b1;
    @(negedge phaseClock);
    resetB = 1'b0;
    total++; if (oB !== RST_EXP) begin bad++; $display("FAIL midframe_reset got=%h exp=%h", oB, RST_EXP); end
    for (int k = 1; k <= 2; k++) begin
      cnt = 0;
      do begin @(negedge phaseClock); cnt++; end while (fsB !== 1'b1 && cnt < 3000);
      total++; if (cnt != 1470) begin bad++; $display("FAIL frame_period_%0d got=%0d exp=1470", k, cnt); end
      total++;
      if (vB !== 9'd0 || hB !== 13'd0 || lpB !== 1'(k % 2) || phB !== 4'((k * 1470) % 16)) begin
        bad++;
        $display("FAIL frame_wrap_%0d got h=%0d v=%0d lp=%b ph=%0d exp h=0 v=0 lp=%b ph=%0d",
                 k, hB, vB, lpB, phB, k % 2, (k * 1470) % 16);
      end
    end
  endtask

  initial begin
    resetA = 1'b0;
    resetB = 1'b0;
    test_reset();
    test_line_timing();
    test_mid_line_reset();
    test_small_frame();
    test_frame_period();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
